alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Arming/zone-tracking FSM for the home alarm system; sits directly upstream of the seven-segment display stage.
- Synchronises four zone sensors and two buttons, sequences DISARMED/EXIT/ARMED/ENTRY/ALARM, and latches tripped zones.
- Drives the display's 5-bit input: bit 4 = armed, bits 3:0 = latched zones. Also drives the siren and a delay LED.

Parameters:
- TICK_DIV, 100000000, clk cycles per delay tick (1 Hz on 100 MHz); must be >= 2.
- EXIT_TICKS, 10, exit-delay length in ticks; must be >= 1.
- ENTRY_TICKS, 10, entry-delay length in ticks; must be >= 1.
- INSTANT_MASK, 4'b1110, zones that go straight to ALARM. Zones not in the mask start the entry delay.
- DEBOUNCE_CYCLES, 1000000, stable cycles required when SENSOR_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- arm_btn  in  1  raw arm button, level
- disarm_btn  in  1  raw disarm button, level
- sensor  in  4  raw zone sensors, 1 = tripped
- status  out  5  to display: [4] armed, [3:0] latched zones
- siren  out  1  alarm output
- delay_led  out  1  high during EXIT or ENTRY delay
- arm_fault  out  1  one-cycle pulse when an arm request is refused

Behaviour:
- Reset: rst_n is sampled on the rising clk edge; it is synchronous and active-low. While it is low:
  - state goes to DISARMED;
  - status, siren, delay_led and arm_fault go to 0;
  - the prescaler, the delay counter and the sync flops go to 0;
  - the button edge-history registers go to 1.
- Reset mid-operation: all outputs are at reset values on the first edge with rst_n low, and nothing is retained.
- Inputs:
  - Every input passes through a 2-flop synchroniser.
  - Buttons are rising-edge detected after sync. A button held through reset release gives no edge until it is released and pressed again.
- Tick: a free-running prescaler counts 0..TICK_DIV-1. tick is a 1-cycle strobe when the count wraps.
- Delay counter:
  - Loaded with N on state entry and decremented on each tick.
  - The transition fires on the tick where the counter equals 1, so the delay lasts N-1 to N ticks.
- States use a 3-bit encoding: DISARMED, EXIT, ARMED, ENTRY, ALARM.
- DISARMED:
  - Arm edge with all synced sensors 0: go to EXIT, load EXIT_TICKS, clear the zone latch.
  - Arm edge with any synced sensor 1: stay in DISARMED and pulse arm_fault for 1 cycle.
- EXIT:
  - Sensors are ignored.
  - On expiry go to ARMED.
  - Disarm edge: go to DISARMED.
- ARMED:
  - Any synced sensor high: OR it into the zone latch.
  - If any tripped bit is in INSTANT_MASK, go to ALARM. Otherwise go to ENTRY and load ENTRY_TICKS.
- ENTRY:
  - The latch keeps ORing new trips.
  - A trip of an instant zone goes to ALARM at once.
  - On expiry go to ALARM.
  - Disarm edge: go to DISARMED.
- ALARM:
  - siren = 1 and the latch keeps ORing.
  - The siren stays on until a disarm edge, which returns to DISARMED.
- Entering DISARMED clears the zone latch.
- Simultaneous events:
  - Disarm edge beats arm edge, delay expiry and sensor trips in the same cycle.
  - An instant-zone trip beats ENTRY expiry (both lead to ALARM anyway).
- Outputs are registered:
  - status[4] = state in {ARMED, ENTRY, ALARM}.
  - status[3:0] = latch value.
  - delay_led = state in {EXIT, ENTRY}.
- Latency: a raw sensor edge reaches status 3 clk edges later (2 sync edges plus 1 register edge), without debounce.
- The zone latch never clears except on entry to EXIT or entry to DISARMED.

Optional Feature:
- SENSOR_DEBOUNCE_EN defined:
  - After sync, each sensor and button passes through a debouncer.
  - A debouncer's output changes only after its input has been stable for DEBOUNCE_CYCLES consecutive cycles. The counter restarts on any change.
  - This adds DEBOUNCE_CYCLES+1 cycles of latency.
- SENSOR_DEBOUNCE_EN undefined: the synchronised signals are used directly.

Decomposition:
- Package alarm_pkg holds:
  - the state encoding constants;
  - the status bit-index constants (ARMED_BIT = 4, ZONE_LSB = 0, ZONE_W = 4);
  - the default tick constants.
- Sub-module alarm_debounce: a 1-bit sync plus optional debounce. Instantiate it 6 times, once per sensor bit and once per button.

Test Plan (TICK_DIV=4, EXIT_TICKS=3, ENTRY_TICKS=3, INSTANT_MASK=4'b1110, debounce off):
- Reset with rst_n=0 for 2 cycles, all inputs 0 -> status=5'b00000, siren=0, delay_led=0, arm_fault=0.
- Press arm_btn with sensor=0 -> delay_led=1 and status=00000. After about 12 cycles: status=5'b10000, delay_led=0.
- From ARMED, sensor=4'b0001 -> status=5'b10001 and ENTRY. No disarm -> siren=1 after about 12 cycles. Then press disarm -> status=00000, siren=0.
- From ARMED, sensor=4'b0100 -> siren=1 within 4 cycles, status=5'b10100. Then sensor=4'b1000 -> status=5'b11100.
- In DISARMED with sensor=4'b0010, press arm -> exactly one arm_fault pulse and state stays DISARMED. arm and disarm pressed in the same cycle during EXIT -> DISARMED.
- Hold arm_btn high through reset release -> no EXIT entry. Assert rst_n=0 during ALARM -> siren=0 and status=0 on the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared encodings and defaults for the alarm controller slice.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    // status bus layout seen by the display stage
    localparam int ARMED_BIT = 4;
    localparam int ZONE_LSB  = 0;
    localparam int ZONE_W    = 4;
    localparam int STATUS_W  = 5;

    localparam int DEF_TICK_DIV        = 100000000;
    localparam int DEF_EXIT_TICKS      = 10;
    localparam int DEF_ENTRY_TICKS     = 10;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

    typedef struct packed {
        logic armed;
        logic siren;
        logic led;
    } outs_t;

    // Registered output pattern that goes with each state
    function automatic outs_t st_outs(input state_t s);
        outs_t o;
        o.armed = (s == ST_ARMED) || (s == ST_ENTRY) || (s == ST_ALARM);
        o.siren = (s == ST_ALARM);
        o.led   = (s == ST_EXIT) || (s == ST_ENTRY);
        return o;
    endfunction

endpackage

// File: rtl/alarm_if.sv
// Sensor/button inputs and display/siren outputs of the alarm controller.
interface alarm_if;
    import alarm_pkg::*;

    logic                arm_btn;
    logic                disarm_btn;
    logic [ZONE_W-1:0]   sensor;
    logic [STATUS_W-1:0] status;
    logic                siren;
    logic                delay_led;
    logic                arm_fault;

    modport master (
        output arm_btn, disarm_btn, sensor,
        input  status, siren, delay_led, arm_fault
    );

    modport slave (
        input  arm_btn, disarm_btn, sensor,
        output status, siren, delay_led, arm_fault
    );
endinterface

// File: rtl/alarm_debounce.sv
// 1-bit two-flop synchroniser with optional debouncer (SENSOR_DEBOUNCE_EN).
// q_vld marks that q reflects a real post-reset input sample, so edge
// detectors downstream do not mistake the reset-cleared flops for a release.
module alarm_debounce
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_vld
);
    logic [1:0] sync;
    logic [1:0] vld_pipe;

    // synchroniser plus a valid shift register tracking real samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync     <= '0;
            vld_pipe <= '0;
        end else begin
            sync     <= {sync[0], d};
            vld_pipe <= {vld_pipe[0], 1'b1};
        end
    end

`ifdef SENSOR_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          stable;
    logic          last;
    logic          settled;

    // first real sample seeds the output; later changes need a stable run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            stable  <= 1'b0;
            last    <= 1'b0;
            settled <= 1'b0;
        end else if (vld_pipe[1]) begin
            if (!settled) begin
                stable  <= sync[1];
                last    <= sync[1];
                settled <= 1'b1;
                cnt     <= '0;
            end else if (sync[1] != last) begin
                last <= sync[1];
                cnt  <= '0;
            end else if (last != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= last;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign q     = stable;
    assign q_vld = settled;
`else
    assign q     = sync[1];
    assign q_vld = vld_pipe[1];
`endif

endmodule

// File: rtl/alarm_controller.sv
// Arming / zone-tracking FSM feeding the seven-segment display stage.
// Optional input debouncing is enabled with `define SENSOR_DEBOUNCE_EN.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int                TICK_DIV        = DEF_TICK_DIV,
    parameter int                EXIT_TICKS      = DEF_EXIT_TICKS,
    parameter int                ENTRY_TICKS     = DEF_ENTRY_TICKS,
    parameter logic [ZONE_W-1:0] INSTANT_MASK    = 4'b1110,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic     clk,
    input logic     rst_n,
    alarm_if.slave  bus
);
    localparam int NUM_IN  = ZONE_W + 2;
    localparam int ARM_IDX = ZONE_W;
    localparam int DIS_IDX = ZONE_W + 1;
    localparam int PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT    = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
    localparam int DW      = $clog2(MAXT + 1);

    logic [NUM_IN-1:0] raw, syn, syn_vld;
    logic [ZONE_W-1:0] sens, zones;
    logic [PW-1:0]     pre;
    logic [DW-1:0]     dly;
    logic              tick, expire;
    logic              arm_hist, dis_hist, arm_rise, dis_rise;
    logic              arm_fault;
    state_t            state;
    outs_t             outs;

    assign raw = {bus.disarm_btn, bus.arm_btn, bus.sensor};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        alarm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (raw[i]),
            .q     (syn[i]),
            .q_vld (syn_vld[i])
        );
    end

    assign sens     = syn[ZONE_W-1:0] & syn_vld[ZONE_W-1:0];
    assign arm_rise = syn[ARM_IDX] & ~arm_hist & syn_vld[ARM_IDX];
    assign dis_rise = syn[DIS_IDX] & ~dis_hist & syn_vld[DIS_IDX];
    assign tick     = (pre == PW'(TICK_DIV - 1));
    assign expire   = tick && (dly == DW'(1));

    // free-running delay-tick prescaler
    always_ff @(posedge clk) begin
        if (!rst_n)    pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
    end

    // button edge history; held high across reset so a held button is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_hist <= 1'b1;
            dis_hist <= 1'b1;
        end else begin
            if (syn_vld[ARM_IDX]) arm_hist <= syn[ARM_IDX];
            if (syn_vld[DIS_IDX]) dis_hist <= syn[DIS_IDX];
        end
    end

    // arming FSM with registered outputs; disarm always wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_DISARMED;
            outs      <= '0;
            zones     <= '0;
            dly       <= '0;
            arm_fault <= 1'b0;
        end else begin
            arm_fault <= 1'b0;
            if ((state == ST_EXIT || state == ST_ENTRY) && tick)
                dly <= dly - DW'(1);
            if (dis_rise) begin
                state <= ST_DISARMED;
                outs  <= st_outs(ST_DISARMED);
                zones <= '0;
            end else begin
                case (state)
                    ST_DISARMED: if (arm_rise) begin
                        if (|sens) begin
                            arm_fault <= 1'b1;
                        end else begin
                            state <= ST_EXIT;
                            outs  <= st_outs(ST_EXIT);
                            dly   <= DW'(EXIT_TICKS);
                            zones <= '0;
                        end
                    end
                    ST_EXIT: if (expire) begin
                        state <= ST_ARMED;
                        outs  <= st_outs(ST_ARMED);
                    end
                    ST_ARMED: if (|sens) begin
                        zones <= zones | sens;
                        if (|(sens & INSTANT_MASK)) begin
                            state <= ST_ALARM;
                            outs  <= st_outs(ST_ALARM);
                        end else begin
                            state <= ST_ENTRY;
                            outs  <= st_outs(ST_ENTRY);
                            dly   <= DW'(ENTRY_TICKS);
                        end
                    end
                    ST_ENTRY: begin
                        zones <= zones | sens;
                        if (|(sens & INSTANT_MASK) || expire) begin
                            state <= ST_ALARM;
                            outs  <= st_outs(ST_ALARM);
                        end
                    end
                    ST_ALARM: zones <= zones | sens;
                    default: begin
                        state <= ST_DISARMED;
                        outs  <= st_outs(ST_DISARMED);
                        zones <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.status[ARMED_BIT]         = outs.armed;
    assign bus.status[ZONE_LSB +: ZONE_W] = zones;
    assign bus.siren                     = outs.siren;
    assign bus.delay_led                 = outs.led;
    assign bus.arm_fault                 = arm_fault;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller (small tick/delay parameters).
module tb_alarm_controller;
    import alarm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alarm_if bus();

    alarm_controller #(
        .TICK_DIV        (4),
        .EXIT_TICKS      (3),
        .ENTRY_TICKS     (3),
        .INSTANT_MASK    (4'b1110),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       arm;
        logic       dis;
        logic [3:0] sensor;
        int         max_wait;
        logic [4:0] status;
        logic       siren;
        logic       led;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] status;
        logic       siren;
        logic       led;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string n, input logic a, input logic d,
                                input logic [3:0] s, input int w,
                                input logic [4:0] st, input logic sr, input logic l);
        vec_t v;
        v.name = n; v.arm = a; v.dis = d; v.sensor = s; v.max_wait = w;
        v.status = st; v.siren = sr; v.led = l;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Drive a vector, queue its expectation, wait (bounded) for the DUT to
    // reach it, then pop and compare. Buttons are pressed for a few cycles.
    task automatic apply_vec(input vec_t v);
        exp_t e;
        bit   hit;
        bus.arm_btn    = v.arm;
        bus.disarm_btn = v.dis;
        bus.sensor     = v.sensor;
        e.name = v.name; e.status = v.status; e.siren = v.siren; e.led = v.led;
        sb.push_back(e);
        hit = 1'b0;
        for (int c = 0; c < v.max_wait && !hit; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.arm_btn    = 1'b0;
                bus.disarm_btn = 1'b0;
            end
            if (bus.status === v.status && bus.siren === v.siren && bus.delay_led === v.led)
                hit = 1'b1;
        end
        e = sb.pop_front();
        check({e.name, ".status"}, 32'(bus.status), 32'(e.status));
        check({e.name, ".siren"},  32'(bus.siren),  32'(e.siren));
        check({e.name, ".led"},    32'(bus.delay_led), 32'(e.led));
        bus.arm_btn    = 1'b0;
        bus.disarm_btn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  pulses;
        bit  saw_led;

        vecs[0] = mk("arm_exit",     1, 0, 4'b0000, 10, 5'b00000, 0, 1);
        vecs[1] = mk("exit_armed",   0, 0, 4'b0000, 40, 5'b10000, 0, 0);
        vecs[2] = mk("z0_entry",     0, 0, 4'b0001, 10, 5'b10001, 0, 1);
        vecs[3] = mk("entry_expire", 0, 0, 4'b0000, 40, 5'b10001, 1, 0);
        vecs[4] = mk("disarm_alarm", 0, 1, 4'b0000, 10, 5'b00000, 0, 0);
        vecs[5] = mk("arm_exit2",    1, 0, 4'b0000, 10, 5'b00000, 0, 1);
        vecs[6] = mk("exit_armed2",  0, 0, 4'b0000, 40, 5'b10000, 0, 0);
        vecs[7] = mk("z2_instant",   0, 0, 4'b0100,  4, 5'b10100, 1, 0);
        vecs[8] = mk("z3_latch",     0, 0, 4'b1000, 10, 5'b11100, 1, 0);
        vecs[9] = mk("disarm2",      0, 1, 4'b0000, 10, 5'b00000, 0, 0);

        bus.arm_btn    = 1'b0;
        bus.disarm_btn = 1'b0;
        bus.sensor     = 4'b0000;

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.status",    32'(bus.status),    0);
        check("rst.siren",     32'(bus.siren),     0);
        check("rst.led",       32'(bus.delay_led), 0);
        check("rst.arm_fault", 32'(bus.arm_fault), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // arm refused with a zone open: exactly one fault pulse, no EXIT
        bus.sensor = 4'b0010;
        repeat (4) @(negedge clk);
        bus.arm_btn = 1'b1;
        pulses  = 0;
        saw_led = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 3) bus.arm_btn = 1'b0;
            if (bus.arm_fault) pulses++;
            if (bus.delay_led) saw_led = 1'b1;
        end
        check("fault.pulses", 32'(pulses), 1);
        check("fault.no_exit", 32'(saw_led), 0);
        check("fault.status", 32'(bus.status), 0);
        bus.sensor = 4'b0000;
        repeat (4) @(negedge clk);

        // arm and disarm together during EXIT -> disarm wins
        apply_vec(mk("arm_exit3",    1, 0, 4'b0000, 10, 5'b00000, 0, 1));
        apply_vec(mk("both_in_exit", 1, 1, 4'b0000, 10, 5'b00000, 0, 0));

        // arm held through reset release gives no edge
        @(negedge clk);
        rst_n       = 1'b0;
        bus.arm_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        saw_led = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.delay_led) saw_led = 1'b1;
        end
        check("held_arm.no_exit", 32'(saw_led), 0);
        check("held_arm.status",  32'(bus.status), 0);
        bus.arm_btn = 1'b0;
        repeat (3) @(negedge clk);
        apply_vec(mk("rearm_exit",  1, 0, 4'b0000, 10, 5'b00000, 0, 1));
        apply_vec(mk("rearm_armed", 0, 0, 4'b0000, 40, 5'b10000, 0, 0));
        apply_vec(mk("pre_rst_alm", 0, 0, 4'b0100,  6, 5'b10100, 1, 0));

        // reset during ALARM clears everything on the first low edge
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.siren",  32'(bus.siren),     0);
        check("midrst.status", 32'(bus.status),    0);
        check("midrst.led",    32'(bus.delay_led), 0);
        bus.sensor = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst.status", 32'(bus.status), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
